nor_tester: RTL and testbench

Sequential stimulus-and-check engine for a 2-input NOR gate. It drives the gate inputs through all four input combinations, waits a programmable settle time, and samples the gate output. It compares each sample against the NOR truth table and reports pass/fail per vector. It sits beside the gate as its driving end: its x/y outputs feed the gate inputs, and the gate output returns on `z_in`.

---
 rtl/nor_tester_pkg.sv | 21 ++
 rtl/nor_tester.sv | 138 +++++++++++++
 tb/tb_nor_tester.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/nor_tester_pkg.sv
// Shared types and helpers for the NOR gate stimulus-and-check engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package nor_tester_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Number of input combinations of a 2-input gate.
    localparam int NUM_VECTORS = 4;

    // Reference output of a healthy 2-input NOR.
    function automatic logic nor_expected(input logic x, input logic y);
        return ~(x | y);
    endfunction

endpackage

// File: rtl/nor_tester.sv
// Drives a 2-input NOR through all four input vectors, samples its output and scores it.
// Latency: done pulses 4*ROUNDS*(SETTLE_CYCLES+1) cycles after the start-accept edge.
// Backpressure: none; start is accepted only in IDLE and is dropped (not queued) otherwise.
//
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   start               begin a run (sampled in IDLE only)
//   z_in                output of the gate under test
//   x_out, y_out        gate inputs; {x_out,y_out} is the current vector index
//   busy                high from start accept until the done edge
//   done                one-cycle end-of-run pulse
//   pass                run had no mismatches; held until the next accepted start
//   err_vec             sticky per-vector mismatch flags, bit i <-> {x,y}=i
//   fail_count          total mismatches in the run, saturating at 255
module nor_tester
    import nor_tester_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int ROUNDS        = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       z_in,
    output logic       x_out,
    output logic       y_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_vec,
    output logic [7:0] fail_count
);

    localparam int CNT_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam int IDX_W = $clog2(NUM_VECTORS);
    localparam int RND_W = 6;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [IDX_W-1:0]   idx;
    logic [RND_W-1:0]   round;

    // Scoreboard update for the vector currently on the gate inputs.
    logic               mismatch;
    logic [3:0]         err_vec_nxt;
    logic [7:0]         fail_count_nxt;
    logic               last_vec;
    logic [IDX_W-1:0]   idx_inc;

    always_comb begin
        mismatch       = (z_in != nor_expected(x_out, y_out));
        err_vec_nxt    = err_vec;
        fail_count_nxt = fail_count;
        if (mismatch) begin
            err_vec_nxt = err_vec | (4'b0001 << idx);
            if (fail_count != 8'hFF) begin
                fail_count_nxt = fail_count + 8'd1;
            end
        end
        last_vec = (idx == IDX_W'(NUM_VECTORS - 1)) && (round == RND_W'(ROUNDS - 1));
        idx_inc  = idx + IDX_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            idx        <= '0;
            round      <= '0;
            x_out      <= 1'b0;
            y_out      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_vec    <= 4'b0000;
            fail_count <= 8'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        err_vec    <= 4'b0000;
                        fail_count <= 8'd0;
                        pass       <= 1'b0;
                        idx        <= '0;
                        round      <= '0;
                        x_out      <= 1'b0;
                        y_out      <= 1'b0;
                        cnt        <= CNT_W'(SETTLE_CYCLES);
                        busy       <= 1'b1;
                        state      <= ST_SETTLE;
                    end
                end

                ST_SETTLE: begin
                    if (cnt == CNT_W'(1)) begin
                        state <= ST_SAMPLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                ST_SAMPLE: begin
                    err_vec    <= err_vec_nxt;
                    fail_count <= fail_count_nxt;
                    if (last_vec) begin
                        // Result and strobe go out together so pass is valid
                        // in the same cycle as done, final sample included.
                        pass  <= (err_vec_nxt == 4'b0000);
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        x_out <= 1'b0;
                        y_out <= 1'b0;
                        state <= ST_DONE;
                    end else begin
                        idx   <= idx_inc;
                        if (idx == IDX_W'(NUM_VECTORS - 1)) begin
                            round <= round + RND_W'(1);
                        end
                        x_out <= idx_inc[1];
                        y_out <= idx_inc[0];
                        cnt   <= CNT_W'(SETTLE_CYCLES);
                        state <= ST_SETTLE;
                    end
                end

                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nor_tester.sv
module tb_nor_tester;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_v [3];
    logic       z_v     [3];
    logic       x_o     [3];
    logic       y_o     [3];
    logic       busy_o  [3];
    logic       done_o  [3];
    logic       pass_o  [3];
    logic [3:0] err_o   [3];
    logic [7:0] fc_o    [3];
    logic [3:0] tbl     [3];   // behaviour of the gate seen by instance k: z = tbl[k][{x,y}]

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Instance 0: defaults; 1: two rounds; 2: three settle cycles.
    nor_tester #(.SETTLE_CYCLES(2), .ROUNDS(1)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .z_in(z_v[0]),
        .x_out(x_o[0]), .y_out(y_o[0]), .busy(busy_o[0]), .done(done_o[0]),
        .pass(pass_o[0]), .err_vec(err_o[0]), .fail_count(fc_o[0]));
    nor_tester #(.SETTLE_CYCLES(2), .ROUNDS(2)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .z_in(z_v[1]),
        .x_out(x_o[1]), .y_out(y_o[1]), .busy(busy_o[1]), .done(done_o[1]),
        .pass(pass_o[1]), .err_vec(err_o[1]), .fail_count(fc_o[1]));
    nor_tester #(.SETTLE_CYCLES(3), .ROUNDS(1)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .z_in(z_v[2]),
        .x_out(x_o[2]), .y_out(y_o[2]), .busy(busy_o[2]), .done(done_o[2]),
        .pass(pass_o[2]), .err_vec(err_o[2]), .fail_count(fc_o[2]));

    assign z_v[0] = tbl[0][{x_o[0], y_o[0]}];
    assign z_v[1] = tbl[1][{x_o[1], y_o[1]}];
    assign z_v[2] = tbl[2][{x_o[2], y_o[2]}];

    function automatic int s_of(int k);
        return (k == 2) ? 3 : 2;
    endfunction

    function automatic int r_of(int k);
        return (k == 1) ? 2 : 1;
    endfunction

    // Reference: a vector fails wherever the gate table disagrees with NOR.
    function automatic logic [3:0] model_err(logic [3:0] t);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) begin
            int  xb   = i / 2;
            int  yb   = i % 2;
            logic good = ((xb + yb) == 0);
            r[i] = (t[i] != good);
        end
        return r;
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] outs(int k);
        return {17'd0, x_o[k], y_o[k], busy_o[k], done_o[k], pass_o[k], err_o[k], fc_o[k]};
    endfunction

    // One complete run on instance k against gate table t; optionally spams start while busy.
    task automatic run(int k, logic [3:0] t, string tag, bit spam);
        int         s     = s_of(k);
        int         nn    = 4 * r_of(k) * (s + 1);
        logic [3:0] e_err = model_err(t);
        int         e_fc  = $countones(e_err) * r_of(k);
        int         n     = 0;
        int         dones = 0;
        int         done_n = -1;
        bit         seq_ok = 1'b1;
        logic [31:0] at_done = '0;
        tbl[k] = t;
        @(negedge clk);
        start_v[k] = 1'b1;
        @(negedge clk);
        start_v[k] = 1'b0;
        // Accept edge just passed: previous results cleared, busy up.
        check({tag, ".accept_busy"}, {31'd0, busy_o[k]}, 32'd1);
        check({tag, ".accept_clear"}, {19'd0, pass_o[k], err_o[k], fc_o[k]}, 32'd0);
        while (n < nn + 4) begin
            if (n < nn) begin
                int v = (n / (s + 1)) % 4;
                if ({x_o[k], y_o[k]} != 2'(v)) seq_ok = 1'b0;
            end
            if (done_o[k]) begin
                dones++;
                if (done_n < 0) begin
                    done_n  = n;
                    at_done = {18'd0, busy_o[k], pass_o[k], err_o[k], fc_o[k]};
                end
            end
            start_v[k] = (spam && n < nn - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            n++;
        end
        start_v[k] = 1'b0;
        check({tag, ".xy_seq"}, {31'd0, seq_ok}, 32'd1);
        check({tag, ".done_lat"}, done_n, nn);
        check({tag, ".done_cnt"}, dones, 1);
        check({tag, ".result"}, at_done,
              {18'd0, 1'b0, (e_err == 4'b0000), e_err, 8'(e_fc)});
        check({tag, ".held"}, outs(k),
              {17'd0, 2'b00, 1'b0, 1'b0, (e_err == 4'b0000), e_err, 8'(e_fc)});
    endtask

    initial begin
        int n;
        int dones;
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            start_v[k] = 1'b0;
            tbl[k]     = 4'b0001;
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) check($sformatf("reset_u%0d", k), outs(k), 32'd0);
        rst_n = 1'b1;

        run(0, 4'b0001, "healthy", 1'b0);
        run(1, 4'b0000, "stuck0_r2", 1'b0);
        run(0, 4'b1111, "stuck1", 1'b0);
        run(2, 4'b1110, "or_s3", 1'b0);

        // Reset in the third vector: immediate clear, no done, then a clean run.
        tbl[0] = 4'b0001;
        @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (7) @(negedge clk);
        check("rst_mid.vec2", {30'd0, x_o[0], y_o[0]}, 32'd2);
        rst_n = 1'b0;
        #1;
        check("rst_mid.outs", outs(0), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (20) begin
            @(negedge clk);
            if (done_o[0]) dones++;
        end
        check("rst_mid.no_done", dones, 0);
        run(0, 4'b0001, "after_rst", 1'b0);

        // Start spam while busy after a failing run.
        run(0, 4'b1000, "pre_spam", 1'b0);
        run(0, 4'b0001, "spam", 1'b1);

        // start held high: one IDLE cycle then immediate restart.
        tbl[0] = 4'b0001;
        @(negedge clk);
        start_v[0] = 1'b1;
        n = 0;
        while (!done_o[0] && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("b2b.first_done", {31'd0, done_o[0]}, 32'd1);
        @(negedge clk);
        check("b2b.idle_gap", {31'd0, busy_o[0]}, 32'd0);
        @(negedge clk);
        start_v[0] = 1'b0;
        check("b2b.restart", {31'd0, busy_o[0]}, 32'd1);
        n = 0;
        while (!done_o[0] && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("b2b.second_lat", n, 12);
        check("b2b.second_pass", {31'd0, pass_o[0]}, 32'd1);

        // Randomised gate behaviours across all three instances.
        for (int i = 0; i < 8; i++) begin
            int         k = $urandom_range(0, 2);
            logic [3:0] t = 4'($urandom_range(0, 15));
            run(k, t, $sformatf("rand%0d_u%0d", i, k), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
